// File: rtl/hamming_pkg.sv
// Shared types and constants for the SECDED decode engine: FSM states, status flags, data bit positions.
// Pure definitions; no timing and no flow control.
package hamming_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HI, S_RD_LO, S_CAP, S_DEC, S_WR_HI, S_WR_LO, S_DONE
  } state_t;

  localparam logic [1:0] F_NONE   = 2'b00;
  localparam logic [1:0] F_SINGLE = 2'b01;
  localparam logic [1:0] F_DOUBLE = 2'b10;

  // Hamming positions holding message bits d1..d11; positions 1,2,4,8 are parity and 0 is overall parity.
  localparam int DATA_POS [1:11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decode of one 16-bit codeword into 11 data bits and a 2-bit status.
// Zero latency; no flow control.
module hamming_secded_dec
  import hamming_pkg::*;
(
  input  logic [15:0] cw,
  output logic [11:1] d,
  output logic [1:0]  f
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fix;

  always_comb begin
    syn = '0;
    for (int k = 1; k < 16; k++) begin
      if (cw[k]) syn = syn ^ 4'(k);
    end
    par = ^cw;
    fix = cw;
    f   = F_NONE;
    if (par) begin
      f = F_SINGLE;
      // Zero syndrome with odd parity means only p0 flipped, so the data bits are already correct.
      if (syn != 4'd0) fix[syn] = ~cw[syn];
    end else if (syn != 4'd0) begin
      f = F_DOUBLE;
    end
    d = '0;
    for (int j = 1; j <= 11; j++) begin
      d[j] = fix[DATA_POS[j]];
    end
  end

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-mastering engine: reads NUM_MSG codewords, writes decoded data plus status, and counts corrected and double-error codewords.
// Six cycles per codeword; done rises one cycle after the last write. There is no backpressure, and start is ignored while busy.
module hamming_dec_engine
  import hamming_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  output logic          done,
  output logic [7:0]    single_cnt,
  output logic [7:0]    double_cnt
);

  localparam int IW = (NUM_MSG < 2) ? 1 : $clog2(NUM_MSG + 1);
  localparam logic [AW-1:0] SRC = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST = AW'(DST_BASE);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [7:0]      hi_q, lo_q, lo_byte;
  logic [11:1]     dec_d;
  logic [1:0]      dec_f;
  logic [AW-1:0]   off, off_nxt;
  logic            go;

  assign off     = AW'(idx) << 1;
  assign off_nxt = AW'(idx + IW'(1)) << 1;
  assign go      = start && (state == S_IDLE || state == S_DONE);

  hamming_secded_dec u_dec (
    .cw ({hi_q, lo_q}),
    .d  (dec_d),
    .f  (dec_f)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      lo_byte    <= '0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      single_cnt <= '0;
      double_cnt <= '0;
    end else if (go) begin
      state      <= S_RD_HI;
      idx        <= '0;
      done       <= 1'b0;
      single_cnt <= '0;
      double_cnt <= '0;
      mem_rd_en  <= 1'b1;
      mem_addr   <= SRC + AW'(1);
    end else begin
      case (state)
        S_RD_HI: begin
          state    <= S_RD_LO;
          mem_addr <= SRC + off;
        end
        S_RD_LO: begin
          state     <= S_CAP;
          hi_q      <= mem_rdata;
          mem_rd_en <= 1'b0;
        end
        S_CAP: begin
          state <= S_DEC;
          lo_q  <= mem_rdata;
        end
        S_DEC: begin
          state     <= S_WR_HI;
          mem_wr_en <= 1'b1;
          mem_addr  <= DST + off + AW'(1);
          mem_wdata <= {dec_f, 3'b000, dec_d[11:9]};
          lo_byte   <= dec_d[8:1];
          if (dec_f == F_SINGLE && single_cnt != 8'hFF) single_cnt <= single_cnt + 8'd1;
          if (dec_f == F_DOUBLE && double_cnt != 8'hFF) double_cnt <= double_cnt + 8'd1;
        end
        S_WR_HI: begin
          state     <= S_WR_LO;
          mem_addr  <= DST + off;
          mem_wdata <= lo_byte;
        end
        S_WR_LO: begin
          mem_wr_en <= 1'b0;
          idx       <= idx + IW'(1);
          if (idx == IW'(NUM_MSG - 1)) begin
            state <= S_DONE;
          end else begin
            state     <= S_RD_HI;
            mem_rd_en <= 1'b1;
            mem_addr  <= SRC + off_nxt + AW'(1);
          end
        end
        S_DONE:  done  <= 1'b1;
        S_IDLE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Self-checking bench: memory model, write scoreboard, table vectors and control corner cases for the decode engine.
module tb_hamming_dec_engine;

  localparam int NUM_MSG  = 15;
  localparam int SRC_BASE = 30;
  localparam int DST_BASE = 0;
  localparam int AW       = 8;
  localparam int NTBL     = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [7:0]    mem_rdata;
  logic          mem_wr_en;
  logic [7:0]    mem_wdata;
  logic          done;
  logic [7:0]    single_cnt;
  logic [7:0]    double_cnt;

  always #5 clk = ~clk;

  hamming_dec_engine #(
    .NUM_MSG (NUM_MSG),
    .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE),
    .AW      (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .done      (done),
    .single_cnt(single_cnt),
    .double_cnt(double_cnt)
  );

  typedef struct {
    logic [15:0] cw;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  vec_t       tbl [NTBL];
  wr_t        exp_q [$];
  logic [7:0] src_mem [256];
  logic [7:0] res_mem [256];
  int checks = 0, errors = 0;
  int quiet = 0, strobes = 0, overlap = 0;
  int exp_single, exp_double;
  int cyc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] m);
    int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [15:0] c = '0;
    logic [3:0]  s = '0;
    for (int j = 0; j < 11; j++) begin
      if (m[j]) begin
        c[pos[j]] = 1'b1;
        s = s ^ 4'(pos[j]);
      end
    end
    c[1] = s[0];
    c[2] = s[1];
    c[4] = s[2];
    c[8] = s[3];
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    return {c[15:9], c[7:5], c[3]};
  endfunction

  // Synchronous memory: reads come from the codeword image, writes land in a separate result image.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= src_mem[mem_addr];
    if (mem_wr_en) res_mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin : mon
    wr_t e;
    if (mem_rd_en && mem_wr_en) overlap++;
    if (quiet != 0 && (mem_rd_en || mem_wr_en)) strobes++;
    if (mem_wr_en && quiet == 0) begin
      check("wr_range", 32'(mem_addr < 8'(DST_BASE + 2 * NUM_MSG)), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_extra: got write addr %0h data %0h expected none", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  task automatic load_run();
    logic [15:0] cw;
    logic [10:0] m, dd;
    logic [7:0]  lo, hi;
    logic [1:0]  f;
    int nf, b1, b2;
    exp_q.delete();
    exp_single = 0;
    exp_double = 0;
    for (int i = 0; i < NUM_MSG; i++) begin
      if (i < NTBL) begin
        cw = tbl[i].cw;
        lo = tbl[i].lo;
        hi = tbl[i].hi;
      end else begin
        m  = 11'($urandom);
        cw = encode(m);
        nf = int'($urandom_range(0, 2));
        b1 = int'($urandom_range(0, 15));
        b2 = (b1 + int'($urandom_range(1, 15))) % 16;
        if (nf >= 1) cw[b1] = ~cw[b1];
        if (nf == 2) cw[b2] = ~cw[b2];
        dd = (nf == 2) ? extract(cw) : m;
        f  = (nf == 0) ? 2'b00 : (nf == 1) ? 2'b01 : 2'b10;
        hi = {f, 3'b000, dd[10:8]};
        lo = dd[7:0];
      end
      if (hi[7:6] == 2'b01) exp_single++;
      if (hi[7:6] == 2'b10) exp_double++;
      src_mem[SRC_BASE + 2 * i]     = cw[7:0];
      src_mem[SRC_BASE + 2 * i + 1] = cw[15:8];
      exp_q.push_back('{addr: 8'(DST_BASE + 2 * i + 1), data: hi});
      exp_q.push_back('{addr: 8'(DST_BASE + 2 * i), data: lo});
    end
  endtask

  task automatic run(input bit poke, output int n);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_clr", done, 0);
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      start = poke && (n == 20);
    end
    start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{cw: 16'h000F, lo: 8'h01, hi: 8'h00};
    tbl[1] = '{cw: 16'h100F, lo: 8'h01, hi: 8'h40};
    tbl[2] = '{cw: 16'h000E, lo: 8'h01, hi: 8'h40};
    tbl[3] = '{cw: 16'h102F, lo: 8'h83, hi: 8'h80};
    tbl[4] = '{cw: 16'hFFFF, lo: 8'hFF, hi: 8'h07};
    tbl[5] = '{cw: 16'h7FFF, lo: 8'hFF, hi: 8'h47};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_single", single_cnt, 0);
    check("rst_double", double_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // Run 1: table vectors then random traffic, with a stray start mid-run.
    load_run();
    run(1'b1, cyc);
    check("run1_latency", cyc, 91);
    check("run1_pending", exp_q.size(), 0);
    check("run1_single", single_cnt, exp_single);
    check("run1_double", double_cnt, exp_double);
    for (int i = 0; i < NTBL; i++) begin
      check($sformatf("tbl%0d_lo", i), res_mem[DST_BASE + 2 * i], tbl[i].lo);
      check($sformatf("tbl%0d_hi", i), res_mem[DST_BASE + 2 * i + 1], tbl[i].hi);
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", done, 1);
    check("done_rd_en", mem_rd_en, 0);
    check("done_wr_en", mem_wr_en, 0);

    // Run 2: restart from DONE, then abort with reset mid-run.
    load_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_done_clr", done, 0);
    check("restart_single_clr", single_cnt, 0);
    repeat (40) @(posedge clk);
    #1;
    reset = 1'b1;
    quiet = 1;
    #1;
    check("abort_done", done, 0);
    check("abort_wr_en", mem_wr_en, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_strobes", strobes, 0);
    check("abort_done_after", done, 0);
    check("abort_single", single_cnt, 0);
    quiet = 0;

    // Run 3: fresh start from IDLE after the abort.
    load_run();
    run(1'b0, cyc);
    check("run3_latency", cyc, 91);
    check("run3_pending", exp_q.size(), 0);
    check("run3_single", single_cnt, exp_single);
    check("run3_double", double_cnt, exp_double);
    check("rd_wr_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
